// File: rtl/spi_sram_pkg.sv
// Shared opcodes, mode encodings and FSM states for the SPI SRAM responder.
// The mode-register feature is enabled with SPI_SRAM_MODE_REG_EN.
package spi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_WRMR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  localparam logic [7:0] MODE_REG_RST = {MODE_SEQ, 6'b000000};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_MODE_RD,
    ST_MODE_WR,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_sram_responder_edge_sync.sv
// Two-flop synchroniser for one asynchronous pin, followed by an
// edge-detect flop that yields single-cycle rise/fall strobes.
module spi_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;
  assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/spi_sram_responder.sv
// 23LC1024-style SPI mode-0 SRAM responder backed by inferred block RAM.
// Define SPI_SRAM_MODE_REG_EN to decode RDMR/WRMR and enable byte/page modes.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int PAGE_SIZE  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic CSn,
  input  logic SCK,
  input  logic SI,
  output logic SO,
  output logic so_oe,
  output logic busy,
  output logic cmd_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(PAGE_SIZE - 1);

  // Index 0: CSn, 1: SCK, 2: SI. Reset value 0 keeps CSn "unarmed" until seen high.
  logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;
  assign pin_raw = {SI, SCK, CSn};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    spi_edge_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_i     (pin_raw[gi]),
      .level_o (pin_lvl[gi]),
      .rise_o  (pin_rise[gi]),
      .fall_o  (pin_fall[gi])
    );
  end

  logic csn_lvl, csn_rise, csn_fall, sck_rise, sck_fall, si_lvl;
  assign csn_lvl  = pin_lvl[0];
  assign csn_rise = pin_rise[0];
  assign csn_fall = pin_fall[0];
  assign sck_rise = pin_rise[1];
  assign sck_fall = pin_fall[1];
  assign si_lvl   = pin_lvl[2];

  logic unused_sync;
  assign unused_sync = ^{pin_lvl[1], pin_rise[2], pin_fall[2]};

  state_e                state_q;
  logic [4:0]            bit_cnt_q;
  logic [2:0]            bits_left_q;
  logic [7:0]            shift_q, tx_q;
  logic [ADDR_WIDTH-1:0] addr_q, ram_addr_q;
  logic                  is_read_q, byte_done_q, armed_q;
  logic                  so_q, so_oe_q, cmd_err_q;
  logic                  ram_we_q, ram_re_q;
  logic [7:0]            ram_wdata_q, ram_rdata_q;
  logic [7:0]            mode_reg;

`ifdef SPI_SRAM_MODE_REG_EN
  logic [7:0] mode_reg_q;
  assign mode_reg = mode_reg_q;
`else
  assign mode_reg = MODE_REG_RST;
`endif

  logic [7:0]            rx_byte, load_byte;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic                  byte_mode;

  assign rx_byte    = {shift_q[6:0], si_lvl};
  assign addr_shift = {addr_q[ADDR_WIDTH-2:0], si_lvl};
  assign byte_mode  = (mode_reg[7:6] == MODE_BYTE);
  // In byte mode only the first byte of a frame touches the array.
  assign load_byte  = (state_q == ST_MODE_RD)      ? mode_reg :
                      (byte_mode && byte_done_q)   ? 8'h00    : ram_rdata_q;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] m);
    case (m)
      MODE_BYTE: return a;
      MODE_PAGE: return (a & ~PAGE_MASK) | ((a + 1'b1) & PAGE_MASK);
      default:   return a + 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      bits_left_q <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      is_read_q   <= 1'b0;
      byte_done_q <= 1'b0;
      armed_q     <= 1'b0;
      so_q        <= 1'b0;
      so_oe_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_wdata_q <= '0;
`ifdef SPI_SRAM_MODE_REG_EN
      mode_reg_q  <= MODE_REG_RST;
`endif
    end else begin
      cmd_err_q <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_re_q  <= 1'b0;
      armed_q   <= armed_q | csn_lvl;
      // CSn rising wins over any same-cycle SCK edge; partial bytes vanish.
      if (csn_rise) begin
        state_q <= ST_IDLE;
        so_q    <= 1'b0;
        so_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csn_fall && armed_q) begin
              state_q     <= ST_CMD;
              bit_cnt_q   <= '0;
              bits_left_q <= '0;
              byte_done_q <= 1'b0;
              so_q        <= 1'b0;
              so_oe_q     <= 1'b0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                case (rx_byte)
                  OP_READ:  begin state_q <= ST_ADDR; is_read_q <= 1'b1; end
                  OP_WRITE: begin state_q <= ST_ADDR; is_read_q <= 1'b0; end
`ifdef SPI_SRAM_MODE_REG_EN
                  OP_RDMR:  state_q <= ST_MODE_RD;
                  OP_WRMR:  state_q <= ST_MODE_WR;
`endif
                  default:  begin state_q <= ST_IGNORE; cmd_err_q <= 1'b1; end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              addr_q    <= addr_shift;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q <= '0;
                if (is_read_q) begin
                  state_q    <= ST_READ;
                  ram_re_q   <= 1'b1;
                  ram_addr_q <= addr_shift;
                  addr_q     <= next_addr(addr_shift, mode_reg[7:6]);
                end else begin
                  state_q <= ST_WRITE;
                end
              end
            end
          end
          ST_READ, ST_MODE_RD: begin
            if (sck_fall) begin
              so_oe_q <= 1'b1;
              if (bits_left_q == 3'd0) begin
                so_q        <= load_byte[7];
                tx_q        <= {load_byte[6:0], 1'b0};
                bits_left_q <= 3'd7;
                byte_done_q <= 1'b1;
              end else begin
                so_q        <= tx_q[7];
                tx_q        <= {tx_q[6:0], 1'b0};
                bits_left_q <= bits_left_q - 3'd1;
                // Prefetch the next byte while the current bit 0 is on SO.
                if (bits_left_q == 3'd1 && state_q == ST_READ) begin
                  ram_re_q   <= 1'b1;
                  ram_addr_q <= addr_q;
                  addr_q     <= next_addr(addr_q, mode_reg[7:6]);
                end
              end
            end
          end
          ST_WRITE: begin
            if (sck_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q   <= '0;
                byte_done_q <= 1'b1;
                addr_q      <= next_addr(addr_q, mode_reg[7:6]);
                if (!(byte_mode && byte_done_q)) begin
                  ram_we_q    <= 1'b1;
                  ram_wdata_q <= rx_byte;
                  ram_addr_q  <= addr_q;
                end
              end
            end
          end
`ifdef SPI_SRAM_MODE_REG_EN
          ST_MODE_WR: begin
            if (sck_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q   <= '0;
                byte_done_q <= 1'b1;
                if (!byte_done_q) mode_reg_q <= rx_byte;
              end
            end
          end
`endif
          ST_IGNORE: begin
            so_q    <= 1'b0;
            so_oe_q <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (ram_we_q) mem[ram_addr_q] <= ram_wdata_q;
    if (ram_re_q) ram_rdata_q <= mem[ram_addr_q];
  end

  assign SO      = so_q;
  assign so_oe   = so_oe_q;
  assign busy    = ~csn_lvl & armed_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: an SPI mode-0 initiator model
// with hand-computed expected bytes, one printed line per comparison.
module tb_spi_sram_responder;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n, csn, sck, si;
  logic so, so_oe, busy, cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  logic [7:0] rxb, oeb;

  always #5 clk = ~clk;

  spi_sram_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .CSn     (csn),
    .SCK     (sck),
    .SI      (si),
    .SO      (so),
    .so_oe   (so_oe),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  always @(negedge clk) if (cmd_err === 1'b1) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    csn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    csn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Shift nbits MSB-first; SO/so_oe are sampled just before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx, output logic [7:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      si = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = so;
      oe[i] = so_oe;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    xfer(op, 8, rxb, oeb);
    xfer(a[23:16], 8, rxb, oeb);
    xfer(a[15:8], 8, rxb, oeb);
    xfer(a[7:0], 8, rxb, oeb);
  endtask

  task automatic write_bytes(input logic [23:0] a, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [7:0] d2, input int n);
    cs_low();
    send_hdr(8'h02, a);
    xfer(d0, 8, rxb, oeb);
    if (n > 1) xfer(d1, 8, rxb, oeb);
    if (n > 2) xfer(d2, 8, rxb, oeb);
    cs_high();
  endtask

  task automatic read_chk(input string tag, input logic [23:0] a,
                          input logic [7:0] e0, input logic [7:0] e1, input int n);
    cs_low();
    send_hdr(8'h03, a);
    chk({tag, " addr so_oe"}, {24'd0, oeb}, 32'h00);
    xfer(8'h00, 8, rxb, oeb);
    chk({tag, " byte0"}, {24'd0, rxb}, {24'd0, e0});
    chk({tag, " byte0 so_oe"}, {24'd0, oeb}, 32'hFF);
    if (n > 1) begin
      xfer(8'h00, 8, rxb, oeb);
      chk({tag, " byte1"}, {24'd0, rxb}, {24'd0, e1});
    end
    cs_high();
  endtask

  task automatic cmd_frame(input logic [7:0] op, input logic [7:0] d0, input logic [7:0] d1);
    cs_low();
    xfer(op, 8, rxb, oeb);
    xfer(d0, 8, rxb, oeb);
    xfer(d1, 8, rxb, oeb);
    cs_high();
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    csn   = 1'b1;
    sck   = 1'b0;
    si    = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset SO", {31'd0, so}, 32'd0);
    chk("reset so_oe", {31'd0, so_oe}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset cmd_err", {31'd0, cmd_err}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // busy tracks CSn with a short synchroniser delay
    @(negedge clk);
    csn = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy during frame", {31'd0, busy}, 32'd1);
    csn = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy after frame", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

    write_bytes(24'h000010, 8'hA5, 8'h5A, 8'h00, 2);
    read_chk("rd 0x010", 24'h000010, 8'hA5, 8'h5A, 2);

    write_bytes(24'h0003FF, 8'h11, 8'h22, 8'h00, 2);
    read_chk("rd 0x3FF", 24'h0003FF, 8'h11, 8'h00, 1);
    read_chk("rd 0x000", 24'h000000, 8'h22, 8'h00, 1);
    read_chk("rd truncated 0x012010", 24'h012010, 8'hA5, 8'h00, 1);

    // Unknown opcode: one cmd_err pulse, SO held low for the rest of the frame
    base = err_cnt;
    cs_low();
    xfer(8'h9F, 8, rxb, oeb);
    xfer(8'h00, 8, rxb, oeb);
    chk("ignore SO", {24'd0, rxb}, 32'h00);
    chk("ignore so_oe", {24'd0, oeb}, 32'h00);
    xfer(8'h00, 8, rxb, oeb);
    cs_high();
    chk("cmd_err pulses", err_cnt - base, 1);
    read_chk("rd after bad op", 24'h000010, 8'hA5, 8'h5A, 2);

    // Aborted write: only 4 bits of 0xCC before CSn rises
    write_bytes(24'h000020, 8'h33, 8'h00, 8'h00, 1);
    cs_low();
    send_hdr(8'h02, 24'h000020);
    xfer(8'hCC, 4, rxb, oeb);
    cs_high();
    read_chk("rd after abort", 24'h000020, 8'h33, 8'h00, 1);

`ifdef SPI_SRAM_MODE_REG_EN
    cmd_frame(8'h01, 8'h80, 8'h40);
    cs_low();
    xfer(8'h05, 8, rxb, oeb);
    xfer(8'h00, 8, rxb, oeb);
    chk("rdmr byte0", {24'd0, rxb}, 32'h80);
    xfer(8'h00, 8, rxb, oeb);
    chk("rdmr byte1", {24'd0, rxb}, 32'h80);
    cs_high();
    write_bytes(24'h00001F, 8'h01, 8'h02, 8'h03, 3);
    cmd_frame(8'h01, 8'h40, 8'h00);
    read_chk("page rd 0x01F", 24'h00001F, 8'h01, 8'h00, 1);
    read_chk("page rd 0x000", 24'h000000, 8'h02, 8'h03, 2);
    cmd_frame(8'h01, 8'h00, 8'h40);
    read_chk("byte mode rd", 24'h000010, 8'hA5, 8'h00, 2);
`else
    base = err_cnt;
    cmd_frame(8'h05, 8'h00, 8'h00);
    cmd_frame(8'h01, 8'h80, 8'h00);
    chk("rdmr/wrmr unknown", err_cnt - base, 2);
    read_chk("seq rd after wrmr", 24'h000010, 8'hA5, 8'h5A, 2);
`endif

    // Reset in the middle of a READ data byte
    cs_low();
    send_hdr(8'h03, 24'h000010);
    xfer(8'h00, 3, rxb, oeb);
    chk("mid-read bits", {29'd0, rxb[7:5]}, 32'h5);
    chk("mid-read so_oe", {29'd0, oeb[7:5]}, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("rst SO", {31'd0, so}, 32'd0);
    chk("rst so_oe", {31'd0, so_oe}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    cs_high();
    read_chk("rd after reset", 24'h000010, 8'hA5, 8'h5A, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
